// File: rtl/ppu_cmd_pkg.sv
// Shared types and widths for the PPU command buffer.
package ppu_cmd_pkg;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int CMD_W      = 32;
  localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/ppu_cmd_fifo.sv
// Synchronous FIFO holding PPU command words: storage, wrapping pointers,
// occupancy count and full/empty flags. A push while full is accepted only alongside a pop.
module ppu_cmd_fifo
  import ppu_cmd_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [CMD_W-1:0] push_data,
  input  logic             pop,
  output logic [CMD_W-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ppu_cmd_buffer.sv
// Buffers PPU commands from proc and drains them over valid/ready during vblank.
// Optional macro PPU_CMD_DROP_CNT_EN adds a saturating drop_count output.
module ppu_cmd_buffer
  import ppu_cmd_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ppu_send,
  input  logic [CMD_W-1:0]      interface_data,
  input  logic                  vblank,
  output logic                  cmd_valid,
  output logic [CMD_W-1:0]      cmd_data,
  input  logic                  cmd_ready,
  input  logic                  clr_ovf,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic [AW:0]           fifo_count,
  output logic                  overflow
`ifdef PPU_CMD_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_count
`endif
);

  state_t           state;
  logic             slot_free;
  logic             pop;
  logic             drop;
  logic [CMD_W-1:0] pop_data;

  assign slot_free = !cmd_valid || cmd_ready;
  assign pop       = (state == DRAIN) && vblank && !fifo_empty && slot_free;
  // A full FIFO still takes the word when a pop frees a slot on the same edge.
  assign drop      = ppu_send && fifo_full && !pop;

  ppu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ppu_send),
    .push_data (interface_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Output slot and drain FSM: the slot is only loaded by a pop and only emptied by a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT;
      cmd_valid <= 1'b0;
      cmd_data  <= '0;
    end else begin
      if (pop) begin
        cmd_valid <= 1'b1;
        cmd_data  <= pop_data;
      end else if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
      end

      case (state)
        WAIT: begin
          if (vblank && !fifo_empty) state <= DRAIN;
        end
        DRAIN: begin
          if (!vblank)
            state <= (cmd_valid && !cmd_ready) ? FLUSH : WAIT;
          else if (fifo_empty && !cmd_valid)
            state <= WAIT;
        end
        FLUSH: begin
          if (cmd_ready) state <= WAIT;
        end
        default: state <= WAIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

`ifdef PPU_CMD_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_count <= '0;
    else if (clr_ovf)
      drop_count <= drop ? DROP_CNT_W'(1) : '0;
    else if (drop && (drop_count != '1))
      drop_count <= drop_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_ppu_cmd_buffer.sv
// Directed self-checking bench for ppu_cmd_buffer (DEPTH=16).
module tb_ppu_cmd_buffer;
  import ppu_cmd_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ppu_send;
  logic [31:0] interface_data;
  logic        vblank;
  logic        cmd_valid;
  logic [31:0] cmd_data;
  logic        cmd_ready;
  logic        clr_ovf;
  logic        fifo_full;
  logic        fifo_empty;
  logic [4:0]  fifo_count;
  logic        overflow;
`ifdef PPU_CMD_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ppu_cmd_buffer #(.DEPTH(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ppu_send       (ppu_send),
    .interface_data (interface_data),
    .vblank         (vblank),
    .cmd_valid      (cmd_valid),
    .cmd_data       (cmd_data),
    .cmd_ready      (cmd_ready),
    .clr_ovf        (clr_ovf),
    .fifo_full      (fifo_full),
    .fifo_empty     (fifo_empty),
    .fifo_count     (fifo_count),
    .overflow       (overflow)
`ifdef PPU_CMD_DROP_CNT_EN
    ,
    .drop_count     (drop_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    ppu_send       = 1'b1;
    interface_data = w;
    tick();
    ppu_send       = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ppu_send = 1'b0; interface_data = '0;
    vblank = 1'b0; cmd_ready = 1'b0; clr_ovf = 1'b0;
    #12;
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    chk("rst_data",  cmd_data, 32'd0);
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_full",  32'(fifo_full), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ovf",   32'(overflow), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(WAIT));
    tick();
    rst_n = 1'b1;
    tick();

    // Buffer three words outside vblank
    push_word(32'h11); push_word(32'h22); push_word(32'h33);
    chk("t1_count", 32'(fifo_count), 32'd3);
    chk("t1_valid", 32'(cmd_valid), 32'd0);
    tick(); tick();
    chk("t1_hold_valid", 32'(cmd_valid), 32'd0);

    // Drain back-to-back
    vblank = 1'b1; cmd_ready = 1'b1;
    tick();
    chk("t2_e1_valid", 32'(cmd_valid), 32'd0);
    chk("t2_e1_state", 32'(dut.state), 32'(DRAIN));
    tick();
    chk("t2_w0_valid", 32'(cmd_valid), 32'd1);
    chk("t2_w0_data", cmd_data, 32'h11);
    tick();
    chk("t2_w1_data", cmd_data, 32'h22);
    tick();
    chk("t2_w2_data", cmd_data, 32'h33);
    chk("t2_empty", 32'(fifo_empty), 32'd1);
    tick();
    chk("t2_done_valid", 32'(cmd_valid), 32'd0);
    tick();
    chk("t2_state_wait", 32'(dut.state), 32'(WAIT));

    // Push-to-valid latency with vblank already high
    push_word(32'h44);
    chk("lat_p0_valid", 32'(cmd_valid), 32'd0);
    chk("lat_p0_count", 32'(fifo_count), 32'd1);
    tick();
    chk("lat_p1_valid", 32'(cmd_valid), 32'd0);
    tick();
    chk("lat_p2_valid", 32'(cmd_valid), 32'd1);
    chk("lat_p2_data", cmd_data, 32'h44);
    tick();
    chk("lat_p3_valid", 32'(cmd_valid), 32'd0);
    tick();
    chk("lat_state_wait", 32'(dut.state), 32'(WAIT));
    vblank = 1'b0; cmd_ready = 1'b0;
    tick();

    // Backpressure holds the slot
    push_word(32'h11); push_word(32'h22);
    vblank = 1'b1;
    tick(); tick();
    chk("t3_valid", 32'(cmd_valid), 32'd1);
    chk("t3_data", cmd_data, 32'h11);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_data", cmd_data, 32'h11);
      chk("t3_hold_valid", 32'(cmd_valid), 32'd1);
    end
    chk("t3_hold_count", 32'(fifo_count), 32'd1);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk("t3_next_data", cmd_data, 32'h22);
    chk("t3_next_valid", 32'(cmd_valid), 32'd1);
    tick();
    chk("t3_stall_data", cmd_data, 32'h22);
    cmd_ready = 1'b1;
    tick();
    chk("t3_end_valid", 32'(cmd_valid), 32'd0);
    tick();
    chk("t3_state_wait", 32'(dut.state), 32'(WAIT));
    vblank = 1'b0; cmd_ready = 1'b0;
    tick();

    // Fill to capacity, then overflow by one
    for (int i = 0; i < 16; i++) push_word(32'h100 + 32'(i));
    chk("t4_full", 32'(fifo_full), 32'd1);
    chk("t4_count16", 32'(fifo_count), 32'd16);
    chk("t4_ovf_before", 32'(overflow), 32'd0);
    push_word(32'hDEAD);
    chk("t4_ovf_set", 32'(overflow), 32'd1);
    chk("t4_count_keep", 32'(fifo_count), 32'd16);
`ifdef PPU_CMD_DROP_CNT_EN
    chk("t4_drop_cnt", 32'(drop_count), 32'd1);
`endif
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t4_ovf_clr", 32'(overflow), 32'd0);
`ifdef PPU_CMD_DROP_CNT_EN
    chk("t4_drop_clr", 32'(drop_count), 32'd0);
`endif

    // Push into a full FIFO on the same edge as a pop
    vblank = 1'b1; cmd_ready = 1'b1;
    tick();
    chk("t5_pre_full", 32'(fifo_full), 32'd1);
    ppu_send = 1'b1; interface_data = 32'h1AA;
    tick();
    ppu_send = 1'b0;
    chk("t5_count", 32'(fifo_count), 32'd16);
    chk("t5_ovf", 32'(overflow), 32'd0);
    chk("t5_first", cmd_data, 32'h100);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("t5_seq", cmd_data, (i < 16) ? 32'h100 + 32'(i) : 32'h1AA);
    end
    chk("t5_empty", 32'(fifo_empty), 32'd1);
    tick();
    chk("t5_end_valid", 32'(cmd_valid), 32'd0);
    tick();
    vblank = 1'b0; cmd_ready = 1'b0;
    tick();

    // vblank falls with the slot stalled
    push_word(32'h77); push_word(32'h88);
    vblank = 1'b1;
    tick(); tick();
    chk("t6_data", cmd_data, 32'h77);
    vblank = 1'b0;
    tick();
    chk("t6_state_flush", 32'(dut.state), 32'(FLUSH));
    chk("t6_flush_valid", 32'(cmd_valid), 32'd1);
    tick();
    chk("t6_flush_data", cmd_data, 32'h77);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk("t6_xfer_valid", 32'(cmd_valid), 32'd0);
    chk("t6_state_wait", 32'(dut.state), 32'(WAIT));
    tick(); tick();
    chk("t6_idle_valid", 32'(cmd_valid), 32'd0);
    chk("t6_idle_count", 32'(fifo_count), 32'd1);

    // Asynchronous reset in the middle of a drain
    push_word(32'h99);
    vblank = 1'b1;
    tick(); tick();
    chk("t7_pre_valid", 32'(cmd_valid), 32'd1);
    chk("t7_pre_data", cmd_data, 32'h88);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_valid", 32'(cmd_valid), 32'd0);
    chk("t7_rst_data", cmd_data, 32'd0);
    chk("t7_rst_count", 32'(fifo_count), 32'd0);
    chk("t7_rst_empty", 32'(fifo_empty), 32'd1);
    chk("t7_rst_state", 32'(dut.state), 32'(WAIT));
    vblank = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t7_after_valid", 32'(cmd_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
